// File: rtl/tx_udp_ip_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_udp_ip_if
// Brief    : Byte-wide AXI-Stream bundle used on both sides of tx_udp_ip.
// Revision : 1.0
// ============================================================================
interface tx_udp_ip_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser, input  tready);
    modport slave  (input  tdata, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/tx_udp_ip.sv
`default_nettype none
// ============================================================================
// Module   : tx_udp_ip
// Brief    : Prepends IPv4 + UDP headers to a payload byte stream.
// Revision : 1.0
// ============================================================================
module tx_udp_ip #(
    parameter logic [7:0]  TTL     = 8'd64,
    parameter logic [15:0] MAX_LEN = 16'd1472
) (
    input  logic        s_axis_aclk,
    input  logic        reset,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] payload_len,
    tx_udp_ip_if.slave  s_axis,
    tx_udp_ip_if.master m_axis,
    output logic        err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CSUM0 = 3'd1;
    localparam logic [2:0] S_CSUM1 = 3'd2;
    localparam logic [2:0] S_HDR   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_PAD   = 3'd5;
    localparam logic [2:0] S_DROP  = 3'd6;
    localparam logic [4:0] c_HDR_LAST = 5'd27;

    logic [2:0]  r_state, w_next;
    logic [31:0] r_src_ip, r_dst_ip;
    logic [15:0] r_sport, r_dport, r_len, r_id, r_csum, r_rem;
    logic [19:0] r_sum;
    logic [4:0]  r_cnt;
    logic        r_err;

    logic        w_len_bad, w_m_hs;
    logic [15:0] w_tot_len, w_udp_len, w_fold2;
    logic [16:0] w_fold1;
    logic [19:0] w_sum;
    logic [7:0]  w_hdr_byte;

    assign w_len_bad = (payload_len == 16'd0) || (payload_len > MAX_LEN);
    assign w_m_hs    = m_axis.tvalid & m_axis.tready;
    assign w_tot_len = r_len + 16'd28;
    assign w_udp_len = r_len + 16'd8;
    assign err       = r_err;

    // Checksum word is zero during summation, so it is simply left out.
    assign w_sum = 20'h04500 + {4'h0, w_tot_len} + {4'h0, r_id} + 20'h04000
                 + {4'h0, TTL, 8'h11}
                 + {4'h0, r_src_ip[31:16]} + {4'h0, r_src_ip[15:0]}
                 + {4'h0, r_dst_ip[31:16]} + {4'h0, r_dst_ip[15:0]};
    assign w_fold1 = {1'b0, r_sum[15:0]} + {13'd0, r_sum[19:16]};
    // A carry out of the first fold leaves at most 0x000E below, so this cannot overflow.
    assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_cnt)
            5'd0:  w_hdr_byte = 8'h45;
            5'd2:  w_hdr_byte = w_tot_len[15:8];
            5'd3:  w_hdr_byte = w_tot_len[7:0];
            5'd4:  w_hdr_byte = r_id[15:8];
            5'd5:  w_hdr_byte = r_id[7:0];
            5'd6:  w_hdr_byte = 8'h40;
            5'd8:  w_hdr_byte = TTL;
            5'd9:  w_hdr_byte = 8'h11;
            5'd10: w_hdr_byte = r_csum[15:8];
            5'd11: w_hdr_byte = r_csum[7:0];
            5'd12: w_hdr_byte = r_src_ip[31:24];
            5'd13: w_hdr_byte = r_src_ip[23:16];
            5'd14: w_hdr_byte = r_src_ip[15:8];
            5'd15: w_hdr_byte = r_src_ip[7:0];
            5'd16: w_hdr_byte = r_dst_ip[31:24];
            5'd17: w_hdr_byte = r_dst_ip[23:16];
            5'd18: w_hdr_byte = r_dst_ip[15:8];
            5'd19: w_hdr_byte = r_dst_ip[7:0];
            5'd20: w_hdr_byte = r_sport[15:8];
            5'd21: w_hdr_byte = r_sport[7:0];
            5'd22: w_hdr_byte = r_dport[15:8];
            5'd23: w_hdr_byte = r_dport[7:0];
            5'd24: w_hdr_byte = w_udp_len[15:8];
            5'd25: w_hdr_byte = w_udp_len[7:0];
            default: w_hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (s_axis.tvalid && s_axis.tuser)
                         w_next = w_len_bad ? S_DROP : S_CSUM0;
            S_CSUM0: w_next = S_CSUM1;
            S_CSUM1: w_next = S_HDR;
            S_HDR:   if (w_m_hs && r_cnt == c_HDR_LAST) w_next = S_DATA;
            S_DATA:  if (w_m_hs) begin
                         if (r_rem == 16'd1)    w_next = s_axis.tlast ? S_IDLE : S_DROP;
                         else if (s_axis.tlast) w_next = S_PAD;
                     end
            S_PAD:   if (w_m_hs && r_rem == 16'd1) w_next = S_IDLE;
            S_DROP:  if (s_axis.tvalid && s_axis.tlast) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = 8'h00;
        m_axis.tlast  = 1'b0;
        m_axis.tuser  = 1'b0;
        case (r_state)
            // Stray bytes outside a frame are swallowed; start bytes wait.
            S_IDLE: s_axis.tready = s_axis.tvalid & ~s_axis.tuser;
            S_HDR: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = w_hdr_byte;
                m_axis.tuser  = (r_cnt == 5'd0);
            end
            S_DATA: begin
                s_axis.tready = m_axis.tready;
                m_axis.tvalid = s_axis.tvalid;
                m_axis.tdata  = s_axis.tdata;
                m_axis.tlast  = (r_rem == 16'd1);
            end
            S_PAD: begin
                m_axis.tvalid = 1'b1;
                m_axis.tlast  = (r_rem == 16'd1);
            end
            S_DROP:  s_axis.tready = 1'b1;
            default: s_axis.tready = 1'b0;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (reset) begin
            r_src_ip <= 32'd0;
            r_dst_ip <= 32'd0;
            r_sport  <= 16'd0;
            r_dport  <= 16'd0;
            r_len    <= 16'd0;
            r_id     <= 16'd0;
            r_sum    <= 20'd0;
            r_csum   <= 16'd0;
            r_cnt    <= 5'd0;
            r_rem    <= 16'd0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (s_axis.tvalid) begin
                    if (s_axis.tuser) begin
                        r_src_ip <= src_ip;
                        r_dst_ip <= dst_ip;
                        r_sport  <= src_port;
                        r_dport  <= dst_port;
                        r_len    <= payload_len;
                        r_cnt    <= 5'd0;
                        r_err    <= w_len_bad;
                    end else if (s_axis.tlast) begin
                        r_err <= 1'b1;
                    end
                end
                S_CSUM0: r_sum  <= w_sum;
                S_CSUM1: r_csum <= ~w_fold2;
                S_HDR: if (w_m_hs) begin
                    r_cnt <= r_cnt + 5'd1;
                    r_rem <= r_len;
                end
                S_DATA: if (w_m_hs) begin
                    r_rem <= r_rem - 16'd1;
                    if (r_rem == 16'd1) begin
                        r_id  <= r_id + 16'd1;
                        r_err <= ~s_axis.tlast;
                    end else if (s_axis.tlast) begin
                        r_err <= 1'b1;
                    end
                end
                S_PAD: if (w_m_hs) begin
                    r_rem <= r_rem - 16'd1;
                    if (r_rem == 16'd1) r_id <= r_id + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tx_udp_ip.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_udp_ip
// Brief    : Scoreboard bench for tx_udp_ip: header model, padding, drops, reset.
// Revision : 1.0
// ============================================================================
module tb_tx_udp_ip;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] src_ip = '0, dst_ip = '0;
    logic [15:0] src_port = '0, dst_port = '0, payload_len = '0;
    logic        err;

    tx_udp_ip_if s_if();
    tx_udp_ip_if m_if();

    tx_udp_ip dut (
        .s_axis_aclk (clk),
        .reset       (rst),
        .src_ip      (src_ip),
        .dst_ip      (dst_ip),
        .src_port    (src_port),
        .dst_port    (dst_port),
        .payload_len (payload_len),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .err         (err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0;
    int          cyc = 0, err_cnt = 0, exp_err = 0;
    logic [15:0] tb_id = 16'd0;
    bit          bp_en = 0, mon_en = 1;
    logic [9:0]  exp_q[$];
    int          start_q[$];
    bit          prev_stall = 0, prev_sop = 0;
    logic [10:0] prev_word = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ip_csum(input logic [15:0] len, id, input logic [31:0] sip, dip);
        logic [31:0] acc;
        acc = 32'h4500 + 32'(len + 16'd28) + 32'(id) + 32'h4000 + 32'h4011
            + 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
        while (acc[31:16] != 16'd0) acc = 32'(acc[15:0]) + 32'(acc[31:16]);
        return ~acc[15:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        m_if.tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (prev_stall)
                check_val("hold", {21'd0, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {21'd0, prev_word});
            if (m_if.tvalid && m_if.tuser && !prev_sop) begin
                if (start_q.size() == 0) check_val("unexpected_sop", 1, 0);
                else check_val("latency", cyc - start_q.pop_front(), 3);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) check_val("extra_byte", {22'd0, m_if.tuser, m_if.tlast, m_if.tdata}, 32'hFFFF);
                else check_val("byte", {22'd0, m_if.tuser, m_if.tlast, m_if.tdata}, {22'd0, exp_q.pop_front()});
            end
            prev_stall = m_if.tvalid & ~m_if.tready;
            prev_sop   = m_if.tvalid & m_if.tuser;
            prev_word  = {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata};
        end else begin
            prev_stall = 0;
            prev_sop   = 0;
        end
        if (!rst && err) err_cnt++;
    end

    task automatic drive_byte(input logic [7:0] d, input logic l, input logic u, input bit scr);
        bit done = 0;
        s_if.tdata = d; s_if.tlast = l; s_if.tuser = u; s_if.tvalid = 1'b1;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk); done = s_if.tready;
            @(posedge clk); #1;
            if (scr) begin
                src_ip = $urandom; dst_ip = $urandom; src_port = 16'($urandom);
                dst_port = 16'($urandom); payload_len = 16'($urandom); scr = 0;
            end
        end
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        if (!done) check_val("in_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 4000 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            check_val("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic send_frame(input logic [31:0] sip, dip, input logic [15:0] sp, dp, len,
                              input int nin, input logic [7:0] base);
        logic [223:0] h;
        logic [7:0]   d;
        bit           ok;
        wait_drain();
        ok = (len != 16'd0) && (len <= 16'd1472);
        if (ok) begin
            h = {8'h45, 8'h00, len + 16'd28, tb_id, 16'h4000, 8'd64, 8'h11,
                 ip_csum(len, tb_id, sip, dip), sip, dip, sp, dp, len + 16'd8, 16'h0000};
            for (int i = 0; i < 28; i++) exp_q.push_back({(i == 0), 1'b0, h[223 - 8*i -: 8]});
            for (int i = 0; i < int'(len); i++) begin
                d = (i < nin) ? base + 8'(i) : 8'h00;
                exp_q.push_back({1'b0, (i == int'(len) - 1), d});
            end
            if (nin != int'(len)) exp_err++;
            tb_id++;
            start_q.push_back(cyc);
        end else begin
            exp_err++;
        end
        src_ip = sip; dst_ip = dip; src_port = sp; dst_port = dp; payload_len = len;
        for (int i = 0; i < nin; i++) drive_byte(base + 8'(i), (i == nin - 1), (i == 0), (i == 0));
    endtask

    task automatic idle_check_err(input string tag);
        wait_drain();
        repeat (3) @(posedge clk);
        #1 check_val(tag, err_cnt, exp_err);
    endtask

    initial begin
        s_if.tdata = '0; s_if.tvalid = 0; s_if.tlast = 0; s_if.tuser = 0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_m_tvalid", m_if.tvalid, 0);
        check_val("rst_m_tdata",  m_if.tdata, 0);
        check_val("rst_m_tlast",  m_if.tlast, 0);
        check_val("rst_m_tuser",  m_if.tuser, 0);
        check_val("rst_s_tready", s_if.tready, 0);
        check_val("rst_err",      err, 0);
        @(posedge clk); #1 rst = 1'b0;

        // basic frame followed back-to-back by an identical one
        send_frame(32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd18, 18, 8'h00);
        send_frame(32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd18, 18, 8'h00);
        idle_check_err("err_basic");

        bp_en = 1;
        send_frame(32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd18, 18, 8'h00);
        send_frame(32'h0A000001, 32'hFFFFFFFF, 16'hFFFF, 16'h0001, 16'd40, 40, 8'h80);
        idle_check_err("err_backpressure");
        bp_en = 0;

        send_frame(32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd18, 10, 8'h20);
        idle_check_err("err_short");
        send_frame(32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd4, 7, 8'h30);
        idle_check_err("err_long");
        send_frame(32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd0, 3, 8'h40);
        idle_check_err("err_len0");
        send_frame(32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd1473, 2, 8'h50);
        idle_check_err("err_len_max");
        send_frame(32'h01020304, 32'h05060708, 16'd1, 16'd2, 16'd1472, 1472, 8'h00);
        send_frame(32'h01020304, 32'h05060708, 16'd1, 16'd2, 16'd1, 1, 8'hEE);
        idle_check_err("err_boundary");

        // stray byte outside a frame
        drive_byte(8'hAA, 1'b1, 1'b0, 1'b0);
        exp_err++;
        idle_check_err("err_stray");

        // reset in the middle of the header
        mon_en = 0;
        src_ip = 32'h11111111; dst_ip = 32'h22222222; payload_len = 16'd18;
        s_if.tdata = 8'h00; s_if.tuser = 1'b1; s_if.tvalid = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1; s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_m_tvalid", m_if.tvalid, 0);
        check_val("mid_rst_m_tuser",  m_if.tuser, 0);
        check_val("mid_rst_m_tdata",  m_if.tdata, 0);
        check_val("mid_rst_s_tready", s_if.tready, 0);
        check_val("mid_rst_err",      err, 0);
        @(posedge clk); #1 rst = 1'b0; mon_en = 1; tb_id = 16'd0;
        send_frame(32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd18, 18, 8'h00);
        idle_check_err("err_after_reset");

        check_val("sb_empty", exp_q.size(), 0);
        check_val("sop_all_seen", start_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
